// File: rtl/audio_i2s_tx_if.sv
// Sample-source side of the I2S transmitter: per-sample strobe, stereo words and mute.
interface audio_i2s_tx_if;
    logic        sample_valid;
    logic [15:0] left;
    logic [15:0] right;
    logic        mute;

    modport master (output sample_valid, left, right, mute);
    modport slave  (input  sample_valid, left, right, mute);
endinterface

// File: rtl/audio_i2s_tx.sv
// 16-bit stereo I2S serialiser: 64 BCLK/frame, standard I2S alignment, one-deep pending buffer
// with hold-last underrun and newest-wins overrun reporting.
module audio_i2s_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic           clk,
    input  logic           reset,
    audio_i2s_tx_if.slave  src,
    output logic           i2s_bclk,
    output logic           i2s_lrck,
    output logic           i2s_data,
    output logic           frame_start,
    output logic           underrun,
    output logic           overrun
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W  = 6;
    localparam int unsigned SMP_W  = 16;
    localparam int unsigned SLOT_W = 5;
    localparam int unsigned IDX_W  = 4;

    logic [DIV_W-1:0]  div_cnt,    div_cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt,    bit_cnt_nxt;
    logic [SMP_W-1:0]  pend_left,  pend_left_nxt;
    logic [SMP_W-1:0]  pend_right, pend_right_nxt;
    logic              fresh,      fresh_nxt;
    logic [SMP_W-1:0]  word_left,  word_left_nxt;
    logic [SMP_W-1:0]  word_right, word_right_nxt;
    logic              bclk_nxt, lrck_nxt, data_nxt;
    logic              frame_start_nxt, underrun_nxt, overrun_nxt;

    logic              tick, fall, load, in_data;
    logic [BIT_W-1:0]  bit_inc;
    logic [SLOT_W-1:0] slot;
    logic [IDX_W-1:0]  idx;
    logic [SMP_W-1:0]  sel_word;

    // Next-state: divider, serial slot sequencing, frame load and pending-buffer bookkeeping
    always_comb begin
        div_cnt_nxt     = div_cnt;
        bit_cnt_nxt     = bit_cnt;
        pend_left_nxt   = pend_left;
        pend_right_nxt  = pend_right;
        fresh_nxt       = fresh;
        word_left_nxt   = word_left;
        word_right_nxt  = word_right;
        bclk_nxt        = i2s_bclk;
        lrck_nxt        = i2s_lrck;
        data_nxt        = i2s_data;
        frame_start_nxt = 1'b0;
        underrun_nxt    = 1'b0;
        overrun_nxt     = 1'b0;

        tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
        fall     = tick & i2s_bclk;
        bit_inc  = bit_cnt + BIT_W'(1);
        load     = fall && (bit_inc == '0);
        slot     = bit_inc[SLOT_W-1:0];
        in_data  = (slot != '0) && (slot <= SLOT_W'(SMP_W));
        idx      = IDX_W'(SLOT_W'(SMP_W) - slot);
        sel_word = bit_inc[BIT_W-1] ? word_right : word_left;

        div_cnt_nxt = tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) begin
            bclk_nxt = ~i2s_bclk;
        end

        // Slot 0 always carries zero, so the freshly loaded words are never needed this cycle
        if (fall) begin
            bit_cnt_nxt = bit_inc;
            lrck_nxt    = bit_inc[BIT_W-1];
            data_nxt    = in_data ? sel_word[idx] : 1'b0;
        end

        if (load) begin
            word_left_nxt   = src.mute ? '0 : pend_left;
            word_right_nxt  = src.mute ? '0 : pend_right;
            frame_start_nxt = 1'b1;
            underrun_nxt    = ~fresh;
            fresh_nxt       = 1'b0;
        end

        // A write coinciding with a load lands after the load has taken the old pending value
        if (src.sample_valid) begin
            pend_left_nxt  = src.left;
            pend_right_nxt = src.right;
            fresh_nxt      = 1'b1;
            overrun_nxt    = fresh & ~load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            bit_cnt     <= BIT_W'(63);
            pend_left   <= '0;
            pend_right  <= '0;
            fresh       <= 1'b0;
            word_left   <= '0;
            word_right  <= '0;
            i2s_bclk    <= 1'b0;
            i2s_lrck    <= 1'b1;
            i2s_data    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            div_cnt     <= div_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            pend_left   <= pend_left_nxt;
            pend_right  <= pend_right_nxt;
            fresh       <= fresh_nxt;
            word_left   <= word_left_nxt;
            word_right  <= word_right_nxt;
            i2s_bclk    <= bclk_nxt;
            i2s_lrck    <= lrck_nxt;
            i2s_data    <= data_nxt;
            frame_start <= frame_start_nxt;
            underrun    <= underrun_nxt;
            overrun     <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: time-indexed reference model checked every cycle, plus table-driven
// frame vectors and directed multi-cycle corner sequences.
module tb_audio_i2s_tx;

    localparam int D = 2;

    logic clk;
    logic reset;
    logic i2s_bclk, i2s_lrck, i2s_data, frame_start, underrun, overrun;

    audio_i2s_tx_if src_if ();

    audio_i2s_tx #(.CLK_DIV(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .src         (src_if.slave),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_data    (i2s_data),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: t = clocks since reset release; the pins follow from t and the loaded frame
    int          m_t;
    logic [15:0] m_pend_l, m_pend_r, m_word_l, m_word_r;
    logic        m_fresh;
    int          ov_seen;
    logic        prev_bclk;
    logic        last_fall;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        logic       e_fs, e_ur, e_ov, e_bclk, e_lrck, e_data, load, f0;
        logic [15:0] w;
        int b, s;
        @(posedge clk);
        #1;
        e_fs = 1'b0; e_ur = 1'b0; e_ov = 1'b0;
        if (reset) begin
            m_t = 0; m_pend_l = '0; m_pend_r = '0; m_word_l = '0; m_word_r = '0; m_fresh = 1'b0;
        end else begin
            m_t++;
            load = (m_t % (2*D) == 0) && (((m_t / (2*D)) - 1) % 64 == 0);
            f0   = m_fresh;
            e_fs = load;
            e_ur = load && !f0;
            e_ov = src_if.sample_valid && f0 && !load;
            if (load) begin
                m_word_l = src_if.mute ? 16'h0 : m_pend_l;
                m_word_r = src_if.mute ? 16'h0 : m_pend_r;
                m_fresh  = 1'b0;
            end
            if (src_if.sample_valid) begin
                m_pend_l = src_if.left;
                m_pend_r = src_if.right;
                m_fresh  = 1'b1;
            end
        end
        e_bclk = ((m_t / D) % 2) == 1;
        if (m_t < 2*D) begin
            e_lrck = 1'b1;
            e_data = 1'b0;
        end else begin
            b = ((m_t / (2*D)) - 1) % 64;
            s = b % 32;
            w = (b >= 32) ? m_word_r : m_word_l;
            e_lrck = (b >= 32);
            e_data = (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
        end
        check("cycle_pins", {26'd0, i2s_bclk, i2s_lrck, i2s_data, frame_start, underrun, overrun},
              {26'd0, e_bclk, e_lrck, e_data, e_fs, e_ur, e_ov});
        if (overrun === 1'b1) ov_seen++;
        last_fall = prev_bclk && !i2s_bclk;
        prev_bclk = i2s_bclk;
        src_if.sample_valid = 1'b0;
    endtask

    task automatic wait_frame_start(output int cycles);
        logic found = 1'b0;
        cycles = 0;
        for (int i = 0; i < 140*D && !found; i++) begin
            step();
            cycles++;
            if (frame_start === 1'b1) found = 1'b1;
        end
        check("frame_start_seen", {31'd0, found}, 32'd1);
    endtask

    // Called on the load cycle; walks slots 1..63 sampling at each falling BCLK
    task automatic capture_frame(output logic [15:0] l, output logic [15:0] r,
                                 output logic zero_ok, output logic lr_ok);
        logic got;
        l = '0; r = '0; zero_ok = 1'b1; lr_ok = 1'b1;
        for (int s = 1; s < 64; s++) begin
            got = 1'b0;
            for (int i = 0; i < 4*D && !got; i++) begin
                step();
                got = last_fall;
            end
            if (!got) begin
                check("capture_fall_seen", 32'd0, 32'd1);
                return;
            end
            if (i2s_lrck !== (s >= 32)) lr_ok = 1'b0;
            if (s >= 1 && s <= 16)       l[16 - s] = i2s_data;
            else if (s >= 33 && s <= 48) r[48 - s] = i2s_data;
            else if (i2s_data !== 1'b0)  zero_ok = 1'b0;
        end
    endtask

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        src_if.left = l;
        src_if.right = r;
        src_if.sample_valid = 1'b1;
        step();
    endtask

    typedef struct {
        int          n;
        logic [15:0] l1, r1, l2, r2;
        logic        mute;
        logic [15:0] el, er;
        logic        eur;
        int          eov;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [15:0] cl, cr;
        logic zok, lok;
        int cyc;

        vt[0] = '{1, 16'hA5C3, 16'h8001, 16'h0000, 16'h0000, 1'b0, 16'hA5C3, 16'h8001, 1'b0, 0};
        vt[1] = '{2, 16'h1111, 16'h1111, 16'h2222, 16'h2222, 1'b0, 16'h2222, 16'h2222, 1'b0, 1};
        vt[2] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h2222, 16'h2222, 1'b1, 0};
        vt[3] = '{1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 0};
        vt[4] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 0};

        reset = 1'b1;
        src_if.sample_valid = 1'b0; src_if.left = '0; src_if.right = '0; src_if.mute = 1'b0;
        prev_bclk = 1'b0; last_fall = 1'b0; ov_seen = 0;
        m_t = 0; m_fresh = 1'b0;
        m_pend_l = '0; m_pend_r = '0; m_word_l = '0; m_word_r = '0;
        repeat (3) step();
        check("reset_bclk", {31'd0, i2s_bclk}, 32'd0);
        check("reset_lrck", {31'd0, i2s_lrck}, 32'd1);
        check("reset_pulses", {29'd0, frame_start, underrun, overrun}, 32'd0);

        // First frame: load 2*D clocks after release, underrun because nothing was written
        reset = 1'b0;
        wait_frame_start(cyc);
        check("first_load_latency", 32'(cyc), 32'(2*D));
        check("first_underrun", {31'd0, underrun}, 32'd1);
        capture_frame(cl, cr, zok, lok);
        check("frame0_data", {cl, cr}, 32'd0);
        check("frame0_zero_slots", {31'd0, zok}, 32'd1);

        foreach (vt[k]) begin
            ov_seen = 0;
            src_if.mute = vt[k].mute;
            if (vt[k].n >= 1) strobe(vt[k].l1, vt[k].r1);
            if (vt[k].n >= 2) begin
                step();
                strobe(vt[k].l2, vt[k].r2);
            end
            wait_frame_start(cyc);
            check("vec_underrun", {31'd0, underrun}, {31'd0, vt[k].eur});
            src_if.mute = 1'b0;
            capture_frame(cl, cr, zok, lok);
            check("vec_words", {cl, cr}, {vt[k].el, vt[k].er});
            check("vec_zero_slots", {31'd0, zok}, 32'd1);
            check("vec_lrck", {31'd0, lok}, 32'd1);
            check("vec_overruns", 32'(ov_seen), 32'(vt[k].eov));
        end

        // Write landing exactly on the load cycle: load takes the older pending word
        ov_seen = 0;
        strobe(16'h0001, 16'h0001);
        repeat (2*D - 2) step();
        strobe(16'h7FFF, 16'h7FFF);
        check("sim_load_fs", {31'd0, frame_start}, 32'd1);
        check("sim_load_flags", {30'd0, underrun, overrun}, 32'd0);
        capture_frame(cl, cr, zok, lok);
        check("sim_frame_a", {cl, cr}, 32'h0001_0001);
        wait_frame_start(cyc);
        check("sim_next_underrun", {31'd0, underrun}, 32'd0);
        capture_frame(cl, cr, zok, lok);
        check("sim_frame_b", {cl, cr}, 32'h7FFF_7FFF);
        check("sim_overruns", 32'(ov_seen), 32'd0);

        // Reset mid-frame at bit 20
        wait_frame_start(cyc);
        for (int f = 0; f < 20; f++) begin
            step();
            while (!last_fall) step();
        end
        check("bit20_lrck", {31'd0, i2s_lrck}, 32'd0);
        reset = 1'b1;
        step();
        check("midreset_pins", {29'd0, i2s_bclk, i2s_lrck, i2s_data}, 32'b010);
        reset = 1'b0;
        wait_frame_start(cyc);
        check("restart_latency", 32'(cyc), 32'(2*D));

        // Randomised traffic, mute toggles and occasional resets against the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                src_if.left = 16'($urandom);
                src_if.right = 16'($urandom);
                src_if.sample_valid = 1'b1;
            end
            if ($urandom_range(0, 699) == 0) src_if.mute = ~src_if.mute;
            reset = ($urandom_range(0, 2499) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
